// File: rtl/nand_operand_sequencer.sv
// nand_operand_sequencer
//   Feeds the 1-bit NAND accumulator core. A host writes a small program of
//   1-bit operands while the block is idle. On start the block streams the
//   first len operands onto the core's d input, one per clock, and strobes
//   the core's load input with the first one. done pulses in the cycle the
//   core's accumulator holds the final result.
//
// Ports
//   clk        : system clock, rising edge
//   preset     : asynchronous active-high reset (also clears program memory)
//   wr_en      : program-memory write strobe, honoured in IDLE only
//   wr_addr    : program-memory write address
//   wr_data    : operand bit to write
//   start      : begin streaming, honoured in IDLE only
//   len        : operand count sampled with start (0 = no-op, >DEPTH clamped)
//   abort      : cancel a run in progress
//   d_out      : operand bit to the core's d input (registered)
//   acc_preset : load strobe to the core's preset input (registered)
//   busy       : high while streaming
//   done       : one-cycle pulse, core result valid
//   pc         : index of the operand currently on d_out
module nand_operand_sequencer #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          preset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          d_out,
    output logic          acc_preset,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             d_q, d_d;
    logic             ap_q, ap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [AW:0]      len_clamped;
    logic [AW-1:0]    pc_nxt;
    logic             last_op;

    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign pc_nxt      = pc_q + AW'(1);
    // len_q is never 0 in RUN, so len_q-1 cannot underflow there.
    assign last_op     = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q <= S_IDLE;
            mem_q   <= '0;
            len_q   <= '0;
            pc_q    <= '0;
            d_q     <= 1'b0;
            ap_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            d_q     <= d_d;
            ap_q    <= ap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        len_d   = len_q;
        pc_d    = pc_q;
        d_d     = d_q;
        ap_d    = ap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_en)
                    mem_d[wr_addr] = wr_data;
                if (start && (len != '0)) begin
                    state_d = S_RUN;
                    len_d   = len_clamped;
                    pc_d    = '0;
                    // Read through mem_d so a same-cycle write to slot 0 is seen.
                    d_d     = mem_d[0];
                    ap_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    d_d     = 1'b0;
                    ap_d    = 1'b0;
                    busy_d  = 1'b0;
                    pc_d    = '0;
                end else if (last_op) begin
                    state_d = S_DONE;
                    d_d     = 1'b0;
                    ap_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pc_d    = pc_nxt;
                    d_d     = mem_q[pc_nxt];
                    ap_d    = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign d_out      = d_q;
    assign acc_preset = ap_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_nand_operand_sequencer.sv
// Self-checking bench for nand_operand_sequencer. A reference model of the
// operand program (plain array) plus the expected NAND fold produce every
// expected value; a tiny model of the downstream core, fed by the DUT's
// outputs, checks the timing contract at the done pulse.
module tb_nand_operand_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          preset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          d_out;
    logic          acc_preset;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;

    bit mem_m [DEPTH];
    logic core_acc;

    nand_operand_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .preset(preset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .len(len), .abort(abort),
        .d_out(d_out), .acc_preset(acc_preset), .busy(busy), .done(done),
        .pc(pc)
    );

    always #5 clk = ~clk;

    // Downstream core: load on acc_preset, otherwise NAND in d each cycle.
    always @(posedge clk)
        core_acc <= acc_preset ? d_out : ~(core_acc & d_out);

    task automatic write_mem(input int a, input bit v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mem_m[a] = v;
    endtask

    // Run a program of len_req operands. abort_k >= 0 aborts in that cycle.
    // junk drives wr_en/start during the run and the DONE cycle.
    // co_wr writes co_addr/co_data in the same cycle as start.
    task automatic run(input int len_req, input int abort_k, input bit junk,
                       input bit co_wr, input int co_addr, input bit co_data);
        int n;
        int ja;
        bit exp_r;
        logic [7:0] got, exp;
        n = (len_req > DEPTH) ? DEPTH : len_req;
        if (co_wr) begin
            wr_en = 1'b1; wr_addr = AW'(co_addr); wr_data = co_data;
            mem_m[co_addr] = co_data;
        end
        start = 1'b1; len = (AW+1)'(len_req);
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        exp_r = mem_m[0];
        for (int k = 1; k < n; k++) exp_r = ~(exp_r & mem_m[k]);
        for (int k = 0; k < n; k++) begin
            got = {busy, done, acc_preset, d_out, pc};
            exp = {1'b1, 1'b0, (k == 0), mem_m[k], AW'(k)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_cycle len=%0d k=%0d got=%b exp=%b", len_req, k, got, exp);
            end
            if (k == abort_k) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                got = {busy, done, acc_preset, d_out, pc};
                checks++;
                if (got !== 8'h00) begin
                    errors++;
                    $display("FAIL abort_idle got=%b exp=%b", got, 8'h00);
                end
                @(posedge clk); #1;
                checks++;
                if ({busy, done, acc_preset} !== 3'b000) begin
                    errors++;
                    $display("FAIL abort_no_done got=%b exp=000", {busy, done, acc_preset});
                end
                return;
            end
            if (junk) begin
                ja = (k == 0) ? 2 : int'($urandom_range(DEPTH-1));
                wr_en = 1'b1; wr_addr = AW'(ja); wr_data = ~mem_m[ja];
                start = 1'b1; len = (AW+1)'($urandom);
            end
            @(posedge clk); #1;
            wr_en = 1'b0; start = 1'b0;
        end
        got = {busy, done, acc_preset, d_out, pc};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, AW'(n-1)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL done_cycle len=%0d got=%b exp=%b", len_req, got, exp);
        end
        checks++;
        if (core_acc !== exp_r) begin
            errors++;
            $display("FAIL core_result len=%0d got=%b exp=%b", len_req, core_acc, exp_r);
        end
        if (junk) begin
            ja = int'($urandom_range(DEPTH-1));
            wr_en = 1'b1; wr_addr = AW'(ja); wr_data = ~mem_m[ja];
            start = 1'b1; len = 5'd3;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, acc_preset, d_out} !== 4'b0000) begin
            errors++;
            $display("FAIL after_done got=%b exp=0000", {busy, done, acc_preset, d_out});
        end
    endtask

    task automatic test_reset();
        preset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        start = 0; len = 0; abort = 0;
        #12;
        checks++;
        if ({busy, done, acc_preset, d_out, pc} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {busy, done, acc_preset, d_out, pc}, 8'h00);
        end
        @(posedge clk); #3;
        preset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 1'b0;
    endtask

    task automatic test_basic();
        write_mem(0, 1); write_mem(1, 1); write_mem(2, 0); write_mem(3, 1);
        run(4, -1, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        write_mem(0, 1);
        run(1, -1, 0, 0, 0, 0);
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({busy, done, acc_preset, d_out} !== 4'b0000) begin
                errors++;
                $display("FAIL len_zero c=%0d got=%b exp=0000", c, {busy, done, acc_preset, d_out});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < DEPTH; i++) write_mem(i, 1'($urandom));
        run(20, -1, 0, 0, 0, 0);
    endtask

    task automatic test_ignore_in_run();
        write_mem(2, 0);
        run(6, -1, 1, 0, 0, 0);
        run(DEPTH, -1, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        run(4, 1, 0, 0, 0, 0);
        run(4, -1, 0, 0, 0, 0);
    endtask

    task automatic test_start_with_write();
        run(5, -1, 0, 1, 0, ~mem_m[0]);
    endtask

    task automatic test_preset_midrun();
        logic [7:0] got;
        for (int i = 0; i < 8; i++) write_mem(i, 1);
        start = 1'b1; len = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 preset = 1'b1;
        #1;
        got = {busy, done, acc_preset, d_out, pc};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL preset_midrun got=%b exp=%b", got, 8'h00);
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 1'b0;
        @(posedge clk); #3;
        preset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL preset_no_done got=%b exp=00", {busy, done});
        end
        run(DEPTH, -1, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < 4; w++)
                write_mem(int'($urandom_range(DEPTH-1)), 1'($urandom));
            run(int'($urandom_range(20, 1)),
                ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1,
                1'($urandom), 1'($urandom), int'($urandom_range(DEPTH-1)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_len_zero();
        test_clamp();
        test_ignore_in_run();
        test_abort();
        test_start_with_write();
        test_preset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
